ahb_bus_arbiter: RTL
====================

// Module: ahb_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one AHB address/data bus among NUM_MGR managers.
//  Issues a one-hot address-phase grant and tracks the data-phase owner, which drives the wData mux.
//  Handover happens only at legal points: idle cycles and last beat of fixed bursts, never inside a locked sequence.
//  Sits between the manager instances and the shared bus muxes/decoder.
// PARAMETERS
//  NUM_MGR      4  number of requesting managers (2..16)
//  DEFAULT_MGR  0  index parked on when no requests are pending
//  IDX_W        $clog2(NUM_MGR)  derived; width of owner indices
// PORTS
//  clk        in   1        bus clock; all state changes on rising edge
//  reset      in   1        asynchronous, active-high reset
//  busReq     in   NUM_MGR  per-manager bus request
//  lockReq    in   NUM_MGR  per-manager locked-transfer request
//  trans      in   2        HTRANS of current address owner: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  burst      in   3        HBURST of current owner (0 SINGLE, 1 INCR, 2/3 x4, 4/5 x8, 6/7 x16)
//  ready      in   1        HREADY from the bus
//  grant      out  NUM_MGR  one-hot address-phase grant
//  addrOwner  out  IDX_W    binary index of grant
//  dataOwner  out  IDX_W    index of the manager owning the current data phase
//  mastLock   out  1        high while the granted sequence is locked
// BEHAVIOUR
//  Reset: grant=1<<DEFAULT_MGR, addrOwner=dataOwner=DEFAULT_MGR, mastLock=0, beatsLeft=0, rrPtr=DEFAULT_MGR.
//  accept = ready && trans in {NONSEQ,SEQ}.
//  Burst length: SINGLE=1, x4=4, x8=8, x16=16, INCR=0 (unbounded).
//  beatsLeft (5b):
//   - accept with NONSEQ: load len-1.
//   - accept with SEQ and beatsLeft>0: decrement.
//   - BUSY: hold.
//  lastBeat = accept && ((NONSEQ && len==1) || (SEQ && beatsLeft==1)).
//  INCR never sets lastBeat; it is released only via IDLE.
//  Lock:
//   - accept of NONSEQ with lockReq[addrOwner]=1 sets locked.
//   - ready && trans==IDLE && !lockReq[addrOwner] clears locked.
//   - mastLock = locked, registered.
//  rearb = ready && !locked && (trans==IDLE || lastBeat).
//  On rearb, next grant:
//   - choose the first busReq set, searching addrOwner+1, +2, ... wrapping modulo NUM_MGR, with addrOwner checked last.
//   - busReq==0: park on DEFAULT_MGR.
//  On a rearb that changes grant, rrPtr (the last actual grant) is updated.
//  grant/addrOwner update at the clock edge ending the rearb cycle, so they are visible one cycle later.
//  No rearb: grant holds, even if the owner drops busReq.
//  dataOwner <= addrOwner on every cycle with ready=1; holds while ready=0.
//  ready=0: grant, beatsLeft, locked and dataOwner all frozen.
//  BUSY inside a burst: no rearb.
//  Simultaneous lastBeat and new requests: handover on that edge; the new owner's NONSEQ is legal on the next cycle.
//  reset asserted mid-burst: all state returns to reset values immediately (async); no partial-burst memory.
//  grant is always exactly one-hot; X-free after reset.
// TESTING
//  1. Reset, busReq=0 -> grant=0001, addrOwner=0, mastLock=0.
//  2. Round robin:
//     - busReq=1111 with SINGLE NONSEQ each cycle, ready=1.
//     - Required: grant sequence 0010,0100,1000,0001, one per cycle.
//  3. INCR4 by mgr1 while mgr2 requests:
//     - Required: grant stays 0010 through 4 accepted beats.
//     - Required: grant=0100 on the cycle after the 4th beat.
//  4. ready=0 for 3 cycles mid-INCR8:
//     - Required: grant, dataOwner and beatsLeft unchanged.
//     - Required: handover only after the 8th accepted beat.
//  5. Locked sequence:
//     - mgr3 lockReq=1 across two SINGLE transfers with an IDLE between; mgr0 requesting.
//     - Required: mastLock=1 throughout and no handover until IDLE with lockReq=0.
//     - Then grant=0001.
//  6. Reset asserted mid-INCR16 (beatsLeft=9):
//     - Required: grant=DEFAULT_MGR and beatsLeft=0 immediately.
//     - Required: first post-reset NONSEQ reloads the count cleanly.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter
//   Round-robin arbiter that shares one AHB address/data bus among NUM_MGR
//   managers. It drives a one-hot address-phase grant and tracks which
//   manager owns the current data phase, which steers the write-data mux.
//   The bus is handed over only on an IDLE cycle or on the last beat of a
//   fixed-length burst, and never while a locked sequence is in progress.
//
// Ports
//   clk        in   1        bus clock, rising edge
//   reset      in   1        asynchronous, active-high reset
//   busReq     in   NUM_MGR  per-manager bus request
//   lockReq    in   NUM_MGR  per-manager locked-transfer request
//   trans      in   2        HTRANS of address owner (IDLE/BUSY/NONSEQ/SEQ)
//   burst      in   3        HBURST of address owner
//   ready      in   1        HREADY
//   grant      out  NUM_MGR  one-hot address-phase grant
//   addrOwner  out  IDX_W    binary index of the granted manager
//   dataOwner  out  IDX_W    manager owning the current data phase
//   mastLock   out  1        granted sequence is locked
//
// Lock FSM states
//   state     | meaning
//   ST_OPEN   | no locked sequence; handover allowed at legal points
//   ST_LOCKED | owner is inside a locked sequence; grant is pinned

module ahb_bus_arbiter #(
  parameter int NUM_MGR     = 4,
  parameter int DEFAULT_MGR = 0,
  localparam int IDX_W      = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_MGR-1:0] busReq,
  input  logic [NUM_MGR-1:0] lockReq,
  input  logic [1:0]         trans,
  input  logic [2:0]         burst,
  input  logic               ready,
  output logic [NUM_MGR-1:0] grant,
  output logic [IDX_W-1:0]   addrOwner,
  output logic [IDX_W-1:0]   dataOwner,
  output logic               mastLock
);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MGR);

  // addr_owner doubles as the round-robin pointer: it always holds the
  // most recent actual grant, and the search starts just after it.
  lock_state_t      lock_state, lock_nxt;
  logic [IDX_W-1:0] addr_owner, owner_nxt;
  logic [IDX_W-1:0] data_owner, data_nxt;
  logic [4:0]       beats_left, beats_nxt;

  logic             accept;
  logic             is_idle, is_nonseq, is_seq;
  logic             owner_lock;
  logic [4:0]       burst_len;
  logic             last_beat;
  logic             rearb;
  logic [IDX_W-1:0] pick;
  logic             found;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_state <= ST_OPEN;
      addr_owner <= DEF_IDX;
      data_owner <= DEF_IDX;
      beats_left <= 5'd0;
    end else begin
      lock_state <= lock_nxt;
      addr_owner <= owner_nxt;
      data_owner <= data_nxt;
      beats_left <= beats_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    is_idle    = (trans == TR_IDLE);
    is_nonseq  = (trans == TR_NONSEQ);
    is_seq     = (trans == TR_SEQ);
    accept     = ready && (is_nonseq || is_seq);
    owner_lock = lockReq[addr_owner];

    case (burst)
      3'd0:       burst_len = 5'd1;
      3'd1:       burst_len = 5'd0;   // INCR: unbounded
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      default:    burst_len = 5'd16;
    endcase

    // INCR loads zero so its count can never reach the last-beat value;
    // such a burst is released only by IDLE.
    beats_nxt = beats_left;
    if (accept) begin
      if (is_nonseq)
        beats_nxt = (burst_len == 5'd0) ? 5'd0 : burst_len - 5'd1;
      else if (beats_left != 5'd0)
        beats_nxt = beats_left - 5'd1;
    end

    last_beat = accept && ((is_nonseq && burst_len == 5'd1) ||
                           (is_seq && beats_left == 5'd1));

    lock_nxt = lock_state;
    if (ready) begin
      if (accept && is_nonseq && owner_lock)
        lock_nxt = ST_LOCKED;
      else if (is_idle && !owner_lock)
        lock_nxt = ST_OPEN;
    end

    // Looking at the post-update lock lets the first locked NONSEQ pin the
    // grant immediately and lets the releasing IDLE hand over on the same
    // edge that clears the lock.
    rearb = ready && (lock_nxt == ST_OPEN) && (is_idle || last_beat);

    found = 1'b0;
    pick  = DEF_IDX;
    for (int i = 1; i <= NUM_MGR; i++) begin
      int cand;
      cand = int'(addr_owner) + i;
      if (cand >= NUM_MGR)
        cand = cand - NUM_MGR;
      if (!found && busReq[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end

    owner_nxt = rearb ? pick : addr_owner;
    data_nxt  = ready ? addr_owner : data_owner;
  end

  // Outputs
  always_comb begin
    grant             = '0;
    grant[addr_owner] = 1'b1;
    addrOwner         = addr_owner;
    dataOwner         = data_owner;
    mastLock          = (lock_state == ST_LOCKED);
  end

endmodule
